// File: rtl/cpu_operand_pkg.sv
// Operand-source select encodings shared by the A/B operand muxes and the control FSM.
package cpu_operand_pkg;

    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] src_sel_t;

    localparam src_sel_t SRC_REG_B     = 3'd0;
    localparam src_sel_t SRC_PC_INC    = 3'd1;
    localparam src_sel_t SRC_IMM_SEXT  = 3'd2;
    localparam src_sel_t SRC_IMM_ZEXT  = 3'd3;
    localparam src_sel_t SRC_IMM_UPPER = 3'd4;

    function automatic logic sel_is_legal(src_sel_t sel);
        return sel <= SRC_IMM_UPPER;
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Request/operand bus between decode, the B-operand stage and the ALU.
interface alu_operand_stage_if #(
    parameter int WIDTH   = 32,
    parameter int IMM_W   = 16,
    parameter int RADDR_W = 5
);
    import cpu_operand_pkg::*;

    logic               in_valid;
    logic               in_ready;
    src_sel_t           src_sel;
    logic [WIDTH-1:0]   reg_b;
    logic [RADDR_W-1:0] reg_b_addr;
    logic [IMM_W-1:0]   imm;
    logic               fwd_valid;
    logic [RADDR_W-1:0] fwd_addr;
    logic [WIDTH-1:0]   fwd_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               bad_sel;
    logic               clr_err;

    modport master (
        output in_valid, src_sel, reg_b, reg_b_addr, imm,
               fwd_valid, fwd_addr, fwd_data, out_ready, clr_err,
        input  in_ready, out_valid, out_data, bad_sel
    );

    modport slave (
        input  in_valid, src_sel, reg_b, reg_b_addr, imm,
               fwd_valid, fwd_addr, fwd_data, out_ready, clr_err,
        output in_ready, out_valid, out_data, bad_sel
    );

endinterface

// File: rtl/operand_skid_buffer.sv
// Two-entry valid/ready pipeline register: a main output register plus one skid entry
// that absorbs the request accepted in the cycle the consumer stalls.
module operand_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             main_valid;
    logic             skid_valid;
    logic             accept;
    logic             main_free;

    assign in_ready  = !skid_valid && !reset;
    assign accept    = in_valid && in_ready;
    assign main_free = !main_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (main_free) begin
            // in_ready is low whenever skid holds data, so skid and accept never compete
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU B-operand select: source mux, immediate extension and writeback
// forwarding in front of a two-entry skid buffer, plus a sticky illegal-select flag.
module alu_operand_stage
    import cpu_operand_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int IMM_W   = 16,
    parameter int PC_INC  = 4,
    parameter int RADDR_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    alu_operand_stage_if.slave  bus
);

    logic [WIDTH-1:0] operand;
    logic             illegal;
    logic             fwd_hit;
    logic             accept;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             bad_sel_q;

    // Register 0 reads as constant zero and must never pick up bypass data
    assign fwd_hit = bus.fwd_valid
                  && (bus.fwd_addr == bus.reg_b_addr)
                  && (bus.reg_b_addr != '0);

    always_comb begin
        operand = '0;
        illegal = 1'b0;
        case (bus.src_sel)
            SRC_REG_B:     operand = fwd_hit ? bus.fwd_data : bus.reg_b;
            SRC_PC_INC:    operand = WIDTH'(PC_INC);
            SRC_IMM_SEXT:  operand = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
            SRC_IMM_ZEXT:  operand = {{(WIDTH-IMM_W){1'b0}}, bus.imm};
            SRC_IMM_UPPER: operand = {bus.imm, {(WIDTH-IMM_W){1'b0}}};
            default:       illegal = 1'b1;
        endcase
    end

    assign accept = bus.in_valid && in_ready;

    operand_skid_buffer #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.in_valid),
        .in_ready  (in_ready),
        .in_data   (operand),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data)
    );

    // A new illegal accept takes priority over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            bad_sel_q <= 1'b0;
        end else if (accept && illegal) begin
            bad_sel_q <= 1'b1;
        end else if (bus.clr_err) begin
            bad_sel_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.bad_sel   = bad_sel_q;

endmodule
